score_event_scheduler: RTL and testbench

Controller that sits in front of the 8-bit current-score counter and is the only block driving its increment and clear inputs. It collects point awards from several game-logic requesters (enemy hits, pickups, bonuses), keeps a per-requester pending-point balance, and round-robin drains those balances as single-cycle increment pulses. It also sequences game start by issuing the counter's clear and discarding stale awards.

---
 rtl/score_pkg.sv | 18 +
 rtl/rr_pick.sv | 26 ++
 rtl/score_event_scheduler.sv | 137 +++++++++++++
 tb/tb_score_event_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the score event scheduler.
package score_pkg;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_ISSUE = 2'd2
  } state_e;

  localparam int             SCORE_W   = 8;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 8'hFF;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_PTS_W   = 4;
  localparam int DEF_PEND_W  = 8;
  localparam int DEF_BURST   = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set bit of mask at or after ptr, cyclically.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     mask,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] grant,
  output logic             any
);

  always_comb begin
    logic [PTR_W-1:0] sel;
    grant = '0;
    any   = 1'b0;
    sel   = '0;
    for (int k = 0; k < N; k++) begin
      sel = PTR_W'((int'(ptr) + k) % N);
      if (!any && mask[sel]) begin
        any   = 1'b1;
        grant = sel;
      end
    end
  end

endmodule

// File: rtl/score_event_scheduler.sv
// Score event scheduler: collects point awards and drains them as increment pulses.
// Optional shadow-score saturation guarded by SCORE_SHADOW_EN.
module score_event_scheduler
  import score_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PTS_W   = DEF_PTS_W,
  parameter int PEND_W  = DEF_PEND_W,
  parameter int BURST   = DEF_BURST
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_game,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*PTS_W-1:0] req_points,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     current_score_update,
  output logic                     start_game_en,
  output logic                     busy,
`ifdef SCORE_SHADOW_EN
  output logic                     score_saturated,
`endif
  output state_e                   dbg_state
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PEND_W-1:0] HEADROOM   = PEND_W'((2**PEND_W - 1) - (2**PTS_W - 1));
  localparam logic [3:0]        BURST_LAST = 4'(BURST - 1);

  state_e            state_q, state_d;
  logic [PEND_W-1:0] pend_q [NUM_REQ];
  logic [PEND_W-1:0] pend_d [NUM_REQ];
  logic [NUM_REQ-1:0] nz;
  logic [PTR_W-1:0]  rr_q, rr_d, grant_q, grant_d, pick_idx;
  logic              pick_any;
  logic [3:0]        burst_q, burst_d;
  logic              sat_now, sat_last;

  rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .mask  (nz),
    .ptr   (rr_q),
    .grant (pick_idx),
    .any   (pick_any)
  );

`ifdef SCORE_SHADOW_EN
  localparam logic [SCORE_W-1:0] SCORE_LAST = SCORE_MAX - 8'd1;
  logic [SCORE_W-1:0] shadow_q;

  always_ff @(posedge clk) begin
    if (reset || state_q == S_CLEAR) shadow_q <= '0;
    else if (state_q == S_ISSUE && shadow_q != SCORE_MAX) shadow_q <= shadow_q + 8'd1;
  end

  // The pulse that lands the shadow on 255 ends the burst so no pulse is wasted past the cap.
  assign sat_now         = (shadow_q == SCORE_MAX);
  assign sat_last        = (shadow_q == SCORE_LAST);
  assign score_saturated = !reset && sat_now;
`else
  assign sat_now  = 1'b0;
  assign sat_last = 1'b0;
`endif

  // Handshake: an award transfers on a cycle where req_valid[i] && req_ready[i]; ready
  // does not depend on valid, and a requester may hold valid across refused cycles.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      nz[i]        = (pend_q[i] != '0);
      req_ready[i] = !reset && !start_game && (state_q != S_CLEAR) && (pend_q[i] <= HEADROOM);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_d[i] = pend_q[i];
      if (req_valid[i] && req_ready[i])
        pend_d[i] = pend_d[i] + PEND_W'(req_points[i*PTS_W +: PTS_W]);
      if (state_q == S_ISSUE && grant_q == PTR_W'(i))
        pend_d[i] = pend_d[i] - PEND_W'(1);
      if (state_q == S_CLEAR || (state_q == S_IDLE && sat_now))
        pend_d[i] = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    burst_d = burst_q;
    case (state_q)
      S_CLEAR: begin
        state_d = S_IDLE;
        rr_d    = '0;
        grant_d = '0;
        burst_d = '0;
      end
      S_IDLE: begin
        if (!sat_now && pick_any) begin
          grant_d = pick_idx;
          burst_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        burst_d = burst_q + 4'd1;
        if (pend_d[grant_q] == '0 || burst_q == BURST_LAST || sat_last) begin
          state_d = S_IDLE;
          rr_d    = (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + PTR_W'(1);
        end
      end
      default: state_d = S_CLEAR;
    endcase
    if (start_game) state_d = S_CLEAR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CLEAR;
      rr_q    <= '0;
      grant_q <= '0;
      burst_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) pend_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
      for (int i = 0; i < NUM_REQ; i++) pend_q[i] <= pend_d[i];
    end
  end

  assign current_score_update = !reset && (state_q == S_ISSUE);
  assign start_game_en        = !reset && (state_q == S_CLEAR);
  assign busy                 = !reset && ((state_q != S_IDLE) || (|nz));
  assign dbg_state            = state_q;

endmodule

// File: tb/tb_score_event_scheduler.sv
// Self-checking bench for score_event_scheduler: pulse-cycle scoreboard plus conservation checks.
module tb_score_event_scheduler;
  import score_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int PTS_W   = 4;
  localparam int PEND_W  = 8;
  localparam int BURST   = 4;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     start_game = 1'b0;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ*PTS_W-1:0] req_points = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     current_score_update;
  logic                     start_game_en;
  logic                     busy;
  state_e                   dbg_state;
`ifdef SCORE_SHADOW_EN
  logic                     score_saturated;
`endif

  score_event_scheduler #(
    .NUM_REQ(NUM_REQ), .PTS_W(PTS_W), .PEND_W(PEND_W), .BURST(BURST)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .start_game           (start_game),
    .req_valid            (req_valid),
    .req_points           (req_points),
    .req_ready            (req_ready),
    .current_score_update (current_score_update),
    .start_game_en        (start_game_en),
    .busy                 (busy),
`ifdef SCORE_SHADOW_EN
    .score_saturated      (score_saturated),
`endif
    .dbg_state            (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard: expected pulse cycles, plus a model of the external score counter
  logic [31:0] exp_q[$];
  bit          stamp_mode = 1'b1;
  int          pulse_cnt  = 0;
  int          score      = 0;

  always @(negedge clk) begin
    if (current_score_update) begin
      pulse_cnt++;
      if (stamp_mode) begin
        if (exp_q.size() == 0) check_eq("unexpected_pulse_cycle", cyc, 0);
        else check_eq("pulse_cycle", cyc, exp_q.pop_front());
      end
    end
    if (current_score_update || start_game_en)
      check_eq("update_clear_exclusive", {31'd0, current_score_update & start_game_en}, 0);
    if (start_game_en) score = 0;
    else if (current_score_update && score != 255) score++;
  end

  // Driver tasks
  task automatic push_burst(input int first, input int len);
    for (int k = 0; k < len; k++) exp_q.push_back(first + k);
  endtask

  task automatic drive_awards(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*PTS_W-1:0] p,
                              output int n, output logic [NUM_REQ-1:0] acc);
    @(posedge clk); #1;
    req_valid  = v;
    req_points = p;
    n = cyc;
    @(negedge clk);
    acc = req_ready & v;
    @(posedge clk); #1;
    req_valid  = '0;
    req_points = '0;
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start_game = 1'b1;
    @(posedge clk); #1;
    start_game = 1'b0;
    @(negedge clk);
    check_eq("clear_pulse", {31'd0, start_game_en}, 1);
  endtask

  task automatic at_neg(input int t);
    while (1) begin
      @(negedge clk);
      if (cyc >= t) break;
    end
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    if (busy) check_eq(tag, 32'd0, 32'd1);
  endtask

  initial begin
    int n, base, sum, sge_cnt, busy_cnt, refused;
    logic [NUM_REQ-1:0] acc, v;
    logic [NUM_REQ*PTS_W-1:0] p;

    // Reset values and release
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", {28'd0, req_ready}, 0);
    check_eq("rst_update", {31'd0, current_score_update}, 0);
    check_eq("rst_start_en", {31'd0, start_game_en}, 0);
    check_eq("rst_busy", {31'd0, busy}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    sge_cnt = 0; busy_cnt = 0; base = pulse_cnt;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      if (k == 0) check_eq("first_cycle_start_en", {31'd0, start_game_en}, 1);
      sge_cnt += int'(start_game_en);
      if (k > 0) busy_cnt += int'(busy);
    end
    check_eq("start_en_cycles", sge_cnt, 1);
    check_eq("idle_busy_cycles", busy_cnt, 0);
    check_eq("idle_pulses", pulse_cnt - base, 0);

    // Single award of 3: pulses N+2..N+4, busy falls N+5
    do_start();
    drive_awards(4'b0001, 16'h0003, n, acc);
    push_burst(n + 2, 3);
    check_eq("acc_single", {28'd0, acc}, 1);
    at_neg(n + 4);
    check_eq("busy_last_pulse", {31'd0, busy}, 1);
    at_neg(n + 5);
    check_eq("busy_fall", {31'd0, busy}, 0);
    check_eq("state_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check_eq("score_3", score, 3);
    check_eq("queue_drained_1", exp_q.size(), 0);

    // Two requesters 10 and 6: bursts 4,4,4,2,2 with one bubble between
    do_start();
    drive_awards(4'b0101, {4'd0, 4'd6, 4'd0, 4'd10}, n, acc);
    check_eq("acc_pair", {28'd0, acc}, 5);
    push_burst(n + 2, 4);
    push_burst(n + 7, 4);
    push_burst(n + 12, 4);
    push_burst(n + 17, 2);
    push_burst(n + 20, 2);
    wait_idle("timeout_pair", 100);
    check_eq("queue_drained_2", exp_q.size(), 0);
    check_eq("score_16", score, 16);

    // Extra award to the granted requester mid-burst: 8 + 5 pulses, none lost
    do_start();
    drive_awards(4'b0010, {4'd0, 4'd0, 4'd8, 4'd0}, n, acc);
    push_burst(n + 2, 4);
    push_burst(n + 7, 4);
    push_burst(n + 12, 4);
    push_burst(n + 17, 1);
    @(posedge clk); @(posedge clk); #1;
    req_valid  = 4'b0010;
    req_points = {4'd0, 4'd0, 4'd5, 4'd0};
    @(negedge clk);
    check_eq("ready_during_issue", {31'd0, req_ready[1]}, 1);
    check_eq("issue_in_accept_cycle", {31'd0, current_score_update}, 1);
    @(posedge clk); #1;
    req_valid  = '0;
    req_points = '0;
    wait_idle("timeout_merge", 100);
    check_eq("queue_drained_3", exp_q.size(), 0);
    check_eq("score_13", score, 13);

    // start_game mid-burst: current pulse finishes, one clear, then silence
    do_start();
    drive_awards(4'b1000, {4'd7, 4'd0, 4'd0, 4'd0}, n, acc);
    push_burst(n + 2, 2);
    @(posedge clk); @(posedge clk); #1;
    start_game = 1'b1;
    req_valid  = 4'b0001;
    req_points = 16'h0005;
    @(negedge clk);
    check_eq("ready_low_on_start", {28'd0, req_ready}, 0);
    @(posedge clk); #1;
    start_game = 1'b0;
    req_valid  = '0;
    req_points = '0;
    @(negedge clk);
    check_eq("clear_after_abort", {31'd0, start_game_en}, 1);
    repeat (20) @(negedge clk);
    check_eq("abort_busy", {31'd0, busy}, 0);
    check_eq("queue_drained_4", exp_q.size(), 0);
    check_eq("score_after_abort", score, 0);

    // Headroom: hammer requester 0 with 15-point awards until refusals appear
    stamp_mode = 1'b0;
    do_start();
    base = pulse_cnt; sum = 0; refused = 0;
    for (int k = 0; k < 24; k++) begin
      drive_awards(4'b0001, 16'h000F, n, acc);
      if (acc[0]) sum += 15;
      else refused++;
    end
    wait_idle("timeout_headroom", 2000);
    check_eq("headroom_refused_seen", {31'd0, refused != 0}, 1);
    check_eq("headroom_conservation", pulse_cnt - base, sum);

    // Random awards on all requesters: every accepted point becomes one pulse
    do_start();
    base = pulse_cnt; sum = 0;
    for (int k = 0; k < 40; k++) begin
      v = 4'($urandom_range(0, 15));
      p = 16'($urandom_range(0, 65535));
      drive_awards(v, p, n, acc);
      for (int i = 0; i < NUM_REQ; i++)
        if (acc[i]) sum += int'(p[i*PTS_W +: PTS_W]);
    end
    wait_idle("timeout_random", 4000);
    check_eq("random_conservation", pulse_cnt - base, sum);
    check_eq("random_busy", {31'd0, busy}, 0);

`ifdef SCORE_SHADOW_EN
    // 260 points awarded: only 255 pulses, then saturated and idle
    do_start();
    base = pulse_cnt; sum = 0;
    for (int k = 0; k < 4; k++) begin
      drive_awards(4'b1111, 16'hFFFF, n, acc);
      for (int i = 0; i < NUM_REQ; i++) if (acc[i]) sum += 15;
    end
    drive_awards(4'b0011, {4'd0, 4'd0, 4'd5, 4'd15}, n, acc);
    for (int i = 0; i < 2; i++) if (acc[i]) sum += int'(i == 0 ? 15 : 5);
    check_eq("shadow_awarded", sum, 260);
    wait_idle("timeout_shadow", 2000);
    check_eq("shadow_pulses", pulse_cnt - base, 255);
    check_eq("shadow_saturated", {31'd0, score_saturated}, 1);
    check_eq("shadow_busy", {31'd0, busy}, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
